// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and constants for the I2C request arbiter.
// Command bundle, FSM states, response status codes.
package i2c_req_arbiter_pkg;

  localparam int I2C_ADDR_W    = 7;
  localparam int I2C_MAX_BYTES = 5;
  localparam int I2C_DATA_W    = 40;
  localparam int I2C_LEN_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BADLEN  = 2'b11;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_LEN_W-1:0]  len;
    logic [I2C_DATA_W-1:0] wdata;
  } i2c_cmd_t;

  function automatic logic len_ok(input logic [I2C_LEN_W-1:0] len);
    return (len != '0) && (len <= I2C_LEN_W'(I2C_MAX_BYTES));
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and master-engine-side bus of the arbiter.
// master: the arbiter itself; slave: clients plus the I2C engine.
interface i2c_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import i2c_req_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*I2C_LEN_W-1:0]  req_len;
  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]         rsp_rdata;
  logic [1:0]                    rsp_status;

  logic                          m_start;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic                          m_rw;
  logic [I2C_LEN_W-1:0]          m_len;
  logic [I2C_DATA_W-1:0]         m_wdata;
  logic                          m_abort;
  logic                          m_busy;
  logic                          m_done;
  logic                          m_nack;
  logic [I2C_DATA_W-1:0]         m_rdata;

  modport master (
    input  req_valid, req_addr, req_rw,
    input  req_len, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_status,
    output m_start, m_addr, m_rw,
    output m_len, m_wdata, m_abort,
    input  m_busy, m_done, m_nack,
    input  m_rdata
  );

  modport slave (
    output req_valid, req_addr, req_rw,
    output req_len, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_status,
    input  m_start, m_addr, m_rw,
    input  m_len, m_wdata, m_abort,
    output m_busy, m_done, m_nack,
    output m_rdata
  );

endinterface

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// First asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic          found;
  logic [IW-1:0] sel;

  // Scan N slots starting at ptr; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      sel = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        idx_o      = sel;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master engine among NUM_REQ requesters.
// Round-robin grant, launch, wait with timeout, respond.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic               clk,
  input  logic               rst,
  i2c_req_arbiter_if.master  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_e state_q, state_d;

  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         owner_q;
  i2c_cmd_t              cmd_q;
  logic [CW-1:0]         cnt_q;
  logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]            status_q, status_d;

  logic [NUM_REQ-1:0]    win_gnt;
  logic [IW-1:0]         win_idx;
  logic                  win_any;
  i2c_cmd_t              win_cmd;

  logic                  take_cmd;
  logic                  load_rsp;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic                  m_start;
  logic                  m_abort;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Pull the winning requester's command slices out of the flat buses.
  always_comb begin
    win_cmd.addr  = bus.req_addr[int'(win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
    win_cmd.rw    = bus.req_rw[win_idx];
    win_cmd.len   = bus.req_len[int'(win_idx)*I2C_LEN_W +: I2C_LEN_W];
    win_cmd.wdata = bus.req_wdata[int'(win_idx)*I2C_DATA_W +: I2C_DATA_W];
  end

  // State register; reset drops straight to IDLE with no abort or response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and pulse outputs.
  always_comb begin
    state_d   = state_q;
    take_cmd  = 1'b0;
    load_rsp  = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    rsp_valid = '0;
    m_start   = 1'b0;
    m_abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid && !bus.m_busy) state_d = GRANT;
      end
      GRANT: begin
        if (win_any) begin
          take_cmd  = 1'b1;
          req_ready = win_gnt;
          if (len_ok(win_cmd.len)) begin
            state_d = LAUNCH;
          end else begin
            load_rsp = 1'b1;
            status_d = ST_BADLEN;
            rdata_d  = '0;
            state_d  = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        m_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.m_done) begin
          load_rsp = 1'b1;
          status_d = bus.m_nack ? ST_NACK : ST_OK;
          rdata_d  = (cmd_q.rw && !bus.m_nack) ? bus.m_rdata : '0;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          m_abort  = 1'b1;
          load_rsp = 1'b1;
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted command and owner; advance the rr pointer past the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (take_cmd) begin
      cmd_q   <= win_cmd;
      owner_q <= win_idx;
      ptr_q   <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Timeout counter: cleared at launch, saturating while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == LAUNCH) begin
      cnt_q <= '0;
    end else if (state_q == WAIT && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response data and status, held until the next response is built.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= '0;
      status_q <= ST_OK;
    end else if (load_rsp) begin
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_status = status_q;
  assign bus.m_start    = m_start;
  assign bus.m_abort    = m_abort;
  assign bus.m_addr     = cmd_q.addr;
  assign bus.m_rw       = cmd_q.rw;
  assign bus.m_len      = cmd_q.len;
  assign bus.m_wdata    = cmd_q.wdata;

endmodule
